// File: rtl/reg_readback.sv
// Snapshot one register of a bank on request and stream it out LSB-byte first over valid/ready.
// Optional feature: define REG_READBACK_PARITY_EN to append an XOR parity byte to the stream.
module reg_readback #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       rd_req,
  input  logic [IDX_W-1:0]           rd_idx,
  output logic                       rd_busy,
  output logic                       rd_err,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int unsigned NBYTES = DATA_W / 8;
`ifdef REG_READBACK_PARITY_EN
  localparam int unsigned BEATS  = NBYTES + 1;
  localparam int unsigned SH_W   = DATA_W + 8;
`else
  localparam int unsigned BEATS  = NBYTES;
  localparam int unsigned SH_W   = DATA_W;
`endif
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state;
  logic [SH_W-1:0]    shadow;
  logic [SH_W-1:0]    shadow_shr;
  logic [SH_W-1:0]    cap;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sel;
  logic               idx_ok;

  // Out-of-range indices match no register and leave sel at zero.
  always_comb begin
    sel    = '0;
    idx_ok = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k)) begin
        sel    = regs_flat[k*DATA_W +: DATA_W];
        idx_ok = 1'b1;
      end
    end
  end

`ifdef REG_READBACK_PARITY_EN
  logic [7:0] parity;

  always_comb begin
    parity = '0;
    for (int b = 0; b < NBYTES; b++) begin
      parity = parity ^ sel[b*8 +: 8];
    end
  end

  // Parity rides in the top byte of the shadow so it shifts out after the data.
  assign cap = {parity, sel};
`else
  assign cap = sel;
`endif

  assign shadow_shr = shadow >> 8;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      shadow    <= '0;
      cnt       <= '0;
      rd_busy   <= 1'b0;
      rd_err    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      rd_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (rd_req) begin
            state     <= StSend;
            shadow    <= cap;
            cnt       <= '0;
            rd_busy   <= 1'b1;
            rd_err    <= ~idx_ok;
            out_valid <= 1'b1;
            out_data  <= cap[7:0];
            out_last  <= (LAST_CNT == '0);
          end
        end
        StSend: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= StIdle;
              rd_busy   <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              shadow   <= shadow_shr;
              cnt      <= cnt + CNT_W'(1);
              out_data <= shadow_shr[7:0];
              out_last <= ((cnt + CNT_W'(1)) == LAST_CNT);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
